// File: rtl/rtc_access_sequencer.sv
// RTC access sequencer: power-up init writes, periodic time/timer refresh, config read/commit.
// Optional transaction timeout enabled by defining RTC_SEQ_TIMEOUT_EN.
module rtc_access_sequencer #(
  parameter int unsigned TIME_N      = 7,
  parameter int unsigned TIMER_N     = 3,
  parameter logic [7:0]  TIME_BASE   = 8'h21,
  parameter logic [7:0]  TIMER_BASE  = 8'h41,
  parameter int unsigned GAP_CYC     = 16,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_flag_done,
  input  logic       in_sw1,
  input  logic       in_sw2,
  output logic [1:0] out_funcion_conf,
  output logic [7:0] out_addr_ram_rtc,
  output logic [7:0] out_dato_inicio,
  output logic       out_flag_inicio,
  output logic       out_funcion_w_r,
  output logic       out_en_funcion_rtc,
  output logic       out_timeout,
  output logic [2:0] state_now,
  output logic [3:0] q
);

  typedef enum logic [2:0] {
    StInit  = 3'd0,
    StRead  = 3'd1,
    StGap   = 3'd2,
    StCfg   = 3'd3,
    StWrite = 3'd4
  } state_e;

  localparam logic [3:0] TimeN    = 4'(TIME_N);
  localparam logic [3:0] TimerN   = 4'(TIMER_N);
  localparam logic [3:0] LastRead = 4'(TIME_N + TIMER_N);
  localparam logic [7:0] GapLast  = 8'(GAP_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] q_q, q_d, last;
  logic       en_q, en_d;
  logic [7:0] gap_q, gap_d;
  logic       target_q, target_d;  // 1: timer group under edit, 0: time group
  logic       pending_q, pending_d;
  logic [1:0] conf_q;
  logic       timeout_q, timeout_d;
  logic [7:0] addr_q, addr_d, dato_q, dato_d, idx;
  logic       flag_q, flag_d, wr_q, wr_d;
  logic       abort, init_done;

`ifdef RTC_SEQ_TIMEOUT_EN
  localparam logic [9:0] TimeoutLast = 10'(TIMEOUT_CYC - 1);
  logic [9:0] to_cnt_q;
  logic       init_done_q;

  assign abort     = en_q && !in_flag_done && (to_cnt_q == TimeoutLast);
  assign init_done = init_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q    <= 10'd0;
      init_done_q <= 1'b0;
    end else begin
      to_cnt_q <= (en_q && !in_flag_done && !abort) ? to_cnt_q + 10'd1 : 10'd0;
      if (state_q == StInit && state_d == StRead) init_done_q <= 1'b1;
    end
  end
`else
  assign abort     = 1'b0;
  assign init_done = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StInit;
      q_q       <= 4'd0;
      en_q      <= 1'b0;
      gap_q     <= 8'd0;
      target_q  <= 1'b0;
      pending_q <= 1'b0;
      conf_q    <= 2'd0;
      timeout_q <= 1'b0;
      addr_q    <= 8'h00;
      dato_q    <= 8'h00;
      flag_q    <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      en_q      <= en_d;
      gap_q     <= gap_d;
      target_q  <= target_d;
      pending_q <= pending_d;
      conf_q    <= {in_sw2, in_sw1};
      timeout_q <= timeout_d;
      addr_q    <= addr_d;
      dato_q    <= dato_d;
      flag_q    <= flag_d;
      wr_q      <= wr_d;
    end
  end

  always_comb begin
    unique case (state_q)
      StInit:  last = 4'd2;
      StRead:  last = LastRead;
      StCfg:   last = target_q ? TimeN : TimerN;
      StWrite: last = target_q ? TimerN : TimeN;
      default: last = 4'd0;
    endcase
  end

  // Every transaction ends with a gap cycle (en low) before the next request.
  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    en_d      = en_q;
    gap_d     = gap_q;
    target_d  = target_q;
    pending_d = pending_q;
    timeout_d = 1'b0;
    if (state_q == StGap) begin
      if (gap_q == GapLast) begin
        gap_d = 8'd0;
        if (!init_done) begin
          state_d = StInit;
        end else if (conf_q == 2'd0) begin
          state_d = pending_q ? StWrite : StRead;
        end else begin
          state_d  = StCfg;
          target_d = (conf_q == 2'd3);
        end
      end else begin
        gap_d = gap_q + 8'd1;
      end
    end else if (abort) begin
      en_d      = 1'b0;
      timeout_d = 1'b1;
      q_d       = 4'd0;
      gap_d     = 8'd0;
      state_d   = StGap;
    end else if (!en_q) begin
      en_d = 1'b1;
    end else if (in_flag_done) begin
      en_d = 1'b0;
      if (q_q == last) begin
        q_d = 4'd0;
        unique case (state_q)
          StInit:  state_d = StRead;
          StRead:  state_d = StGap;
          StCfg: begin
            state_d   = StGap;
            pending_d = 1'b1;
          end
          StWrite: begin
            state_d   = StRead;
            pending_d = 1'b0;
          end
          default: state_d = StGap;
        endcase
      end else begin
        q_d = q_q + 4'd1;
      end
    end
  end

  // Transaction fields are decoded from next state so they are registered with en.
  always_comb begin
    addr_d = 8'h00;
    dato_d = 8'h00;
    flag_d = 1'b0;
    wr_d   = 1'b0;
    idx    = {4'd0, q_d};
    unique case (state_d)
      StInit: begin
        flag_d = 1'b1;
        wr_d   = 1'b1;
        case (q_d)
          4'd0: begin addr_d = 8'h02; dato_d = 8'h10; end
          4'd1: begin addr_d = 8'h02; dato_d = 8'h00; end
          default: begin addr_d = 8'h10; dato_d = 8'hD2; end
        endcase
      end
      StRead: begin
        if (q_d == 4'd0)     addr_d = 8'hF0;
        else if (q_d <= TimeN) addr_d = TIME_BASE + idx - 8'd1;
        else                 addr_d = TIMER_BASE + (idx - {4'd0, TimeN} - 8'd1);
      end
      StCfg: begin
        if (target_d) addr_d = (q_d == 4'd0) ? 8'hF1 : TIME_BASE + idx - 8'd1;
        else          addr_d = (q_d == 4'd0) ? 8'hF2 : TIMER_BASE + idx - 8'd1;
      end
      StWrite: begin
        wr_d = 1'b1;
        if (target_d) addr_d = (q_d == TimerN) ? 8'hF2 : TIMER_BASE + idx;
        else          addr_d = (q_d == TimeN) ? 8'hF1 : TIME_BASE + idx;
      end
      default: addr_d = 8'h00;
    endcase
  end

  assign out_funcion_conf   = conf_q;
  assign out_addr_ram_rtc   = addr_q;
  assign out_dato_inicio    = dato_q;
  assign out_flag_inicio    = flag_q;
  assign out_funcion_w_r    = wr_q;
  assign out_en_funcion_rtc = en_q;
  assign out_timeout        = timeout_q;
  assign state_now          = state_q;
  assign q                  = q_q;

endmodule

// File: tb/tb_rtc_access_sequencer.sv
// Scoreboard bench for rtc_access_sequencer: directed sequences, monitor pops on each request.
module tb_rtc_access_sequencer;

`ifdef RTC_SEQ_TIMEOUT_EN
  localparam int unsigned Toc = 8;
`else
  localparam int unsigned Toc = 1023;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_flag_done = 1'b0;
  logic       in_sw1 = 1'b0;
  logic       in_sw2 = 1'b0;
  logic [1:0] out_funcion_conf;
  logic [7:0] out_addr_ram_rtc, out_dato_inicio;
  logic       out_flag_inicio, out_funcion_w_r, out_en_funcion_rtc, out_timeout;
  logic [2:0] state_now;
  logic [3:0] q;

  always #5 clk = ~clk;

  rtc_access_sequencer #(.TIMEOUT_CYC(Toc)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_flag_done       (in_flag_done),
    .in_sw1             (in_sw1),
    .in_sw2             (in_sw2),
    .out_funcion_conf   (out_funcion_conf),
    .out_addr_ram_rtc   (out_addr_ram_rtc),
    .out_dato_inicio    (out_dato_inicio),
    .out_flag_inicio    (out_flag_inicio),
    .out_funcion_w_r    (out_funcion_w_r),
    .out_en_funcion_rtc (out_en_funcion_rtc),
    .out_timeout        (out_timeout),
    .state_now          (state_now),
    .q                  (q)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] dato;
    logic       wr;
    logic       flag;
    logic [3:0] idx;
  } txn_t;

  txn_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   to_seen = 0;
  int   resp_delay = 2;
  bit   stray = 1'b0;
  int   hold_q = 15;

  logic [7:0] read_tab [11] = '{8'hF0, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
                                8'h41, 8'h42, 8'h43};
  logic [7:0] cfg_tmr_tab [8] = '{8'hF1, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
  logic [7:0] cfg_time_tab [4] = '{8'hF2, 8'h41, 8'h42, 8'h43};
  logic [7:0] wr_tmr_tab [4] = '{8'h41, 8'h42, 8'h43, 8'hF2};
  logic [7:0] wr_time_tab [8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'hF1};
  logic [7:0] init_addr [3] = '{8'h02, 8'h02, 8'h10};
  logic [7:0] init_dato [3] = '{8'h10, 8'h00, 8'hD2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d, input logic w, input logic f,
                      input int i);
    txn_t t;
    t.addr = a; t.dato = d; t.wr = w; t.flag = f; t.idx = 4'(i);
    sb.push_back(t);
  endtask

  // kind: 0 init, 1 read, 2 cfg timer-target, 3 cfg time-target, 4 write timer, 5 write time
  task automatic push_seq(input int kind, input int count);
    for (int i = 0; i < count; i++) begin
      case (kind)
        0: push(init_addr[i], init_dato[i], 1'b1, 1'b1, i);
        1: push(read_tab[i], 8'h00, 1'b0, 1'b0, i);
        2: push(cfg_tmr_tab[i], 8'h00, 1'b0, 1'b0, i);
        3: push(cfg_time_tab[i], 8'h00, 1'b0, 1'b0, i);
        4: push(wr_tmr_tab[i], 8'h00, 1'b1, 1'b0, i);
        default: push(wr_time_tab[i], 8'h00, 1'b1, 1'b0, i);
      endcase
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int n = 0;
    while (state_now !== s && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, state_now, s);
  endtask

  task automatic measure_gap(output int len, output logic [2:0] nxt);
    len = 1;
    @(negedge clk);
    while (state_now == 3'd2 && len < 1000) begin
      len++;
      @(negedge clk);
    end
    nxt = state_now;
  endtask

  // Engine model: done after resp_delay cycles of en; optional stray done while en is low.
  initial begin
    int wait_cnt = 0;
    forever begin
      @(negedge clk);
      in_flag_done = 1'b0;
      if (out_en_funcion_rtc) begin
        if (q != 4'(hold_q)) begin
          if (wait_cnt >= resp_delay) begin
            in_flag_done = 1'b1;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
      end else begin
        wait_cnt = 0;
        if (stray) in_flag_done = 1'b1;
      end
    end
  end

  // Monitor: every rising request is popped against the scoreboard; fields must then hold.
  initial begin
    logic prev_en = 1'b0;
    txn_t exp_t, got;
    forever begin
      @(negedge clk);
      if (out_timeout === 1'b1) to_seen++;
      got.addr = out_addr_ram_rtc; got.dato = out_dato_inicio; got.wr = out_funcion_w_r;
      got.flag = out_flag_inicio; got.idx = q;
      if (out_en_funcion_rtc && !prev_en) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_txn: got addr %0h expected none", got.addr);
        end else begin
          exp_t = sb.pop_front();
          check("txn", got, exp_t);
        end
      end else if (out_en_funcion_rtc && prev_en) begin
        check("txn_stable", got, exp_t);
      end
      prev_en = out_en_funcion_rtc;
    end
  end

  initial begin
    int len, n, to_exp;
    logic [2:0] nxt;
    repeat (3) @(negedge clk);
    check("rst_state", state_now, 3'd0);
    check("rst_q", q, 4'd0);
    check("rst_en", out_en_funcion_rtc, 1'b0);
    check("rst_addr", out_addr_ram_rtc, 8'h00);
    check("rst_dato", out_dato_inicio, 8'h00);
    check("rst_flag", out_flag_inicio, 1'b0);
    check("rst_wr", out_funcion_w_r, 1'b0);
    check("rst_timeout", out_timeout, 1'b0);
    check("rst_conf", out_funcion_conf, 2'd0);
    push_seq(0, 3);
    push_seq(1, 11);
    reset = 1'b0;
    @(negedge clk);
    check("first_req_en", out_en_funcion_rtc, 1'b1);

    // Refresh gap length, then mode 3 raised mid-READ
    wait_state(3'd2, "reach_gap0");
    push_seq(1, 11);
    measure_gap(len, nxt);
    check("gap_len", len, 16);
    check("gap0_next", nxt, 3'd1);
    repeat (4) @(negedge clk);
    {in_sw2, in_sw1} = 2'd3;
    wait_state(3'd2, "reach_gap1");
    check("conf_reg", out_funcion_conf, 2'd3);
    push_seq(2, 8);
    measure_gap(len, nxt);
    check("gap1_next_cfg", nxt, 3'd3);
    check("cfg_first_q", q, 4'd0);
    check("cfg_first_en", out_en_funcion_rtc, 1'b0);
    {in_sw2, in_sw1} = 2'd0;
    wait_state(3'd2, "cfg_tmr_done");
    push_seq(4, 4);
    push_seq(1, 11);
    measure_gap(len, nxt);
    check("commit_tmr_write", nxt, 3'd4);
    wait_state(3'd1, "read_after_wr_tmr");

    // Mode 1 with minimum-period done and stray done while en is low
    wait_state(3'd2, "reach_gap2");
    {in_sw2, in_sw1} = 2'd1;
    stray = 1'b1;
    resp_delay = 0;
    push_seq(3, 4);
    measure_gap(len, nxt);
    check("gap2_next_cfg", nxt, 3'd3);
    {in_sw2, in_sw1} = 2'd0;
    wait_state(3'd2, "cfg_time_done");
    push_seq(5, 8);
    push_seq(1, 11);
    measure_gap(len, nxt);
    check("commit_time_write", nxt, 3'd4);
    wait_state(3'd1, "read_after_wr_time");
    wait_state(3'd2, "reach_gap3");
    stray = 1'b0;
    resp_delay = 2;

    // Reset in the middle of a WRITE burst
    {in_sw2, in_sw1} = 2'd3;
    push_seq(2, 8);
    measure_gap(len, nxt);
    check("gap3_next_cfg", nxt, 3'd3);
    {in_sw2, in_sw1} = 2'd0;
    wait_state(3'd2, "cfg_tmr_done2");
    push_seq(4, 4);
    measure_gap(len, nxt);
    check("gap4_next_write", nxt, 3'd4);
    n = 0;
    while (!(state_now == 3'd4 && q == 4'd3 && out_en_funcion_rtc) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("write_q3_reached", q, 4'd3);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_en", out_en_funcion_rtc, 1'b0);
    check("midrst_state", state_now, 3'd0);
    check("midrst_q", q, 4'd0);
    sb.delete();
    push_seq(0, 3);
    push_seq(1, 11);
    reset = 1'b0;
    wait_state(3'd2, "reach_gap5");
    push_seq(1, 11);
    measure_gap(len, nxt);
    check("pending_cleared", nxt, 3'd1);

`ifdef RTC_SEQ_TIMEOUT_EN
    wait_state(3'd2, "reach_gap6");
    push_seq(1, 5);
    push_seq(1, 11);
    hold_q = 4;
    measure_gap(len, nxt);
    check("gap6_next", nxt, 3'd1);
    n = 0;
    while (out_timeout !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("timeout_pulse", out_timeout, 1'b1);
    check("timeout_en", out_en_funcion_rtc, 1'b0);
    check("timeout_state", state_now, 3'd2);
    @(negedge clk);
    check("timeout_one_cycle", out_timeout, 1'b0);
    hold_q = 15;
    to_exp = 1;
`else
    to_exp = 0;
`endif

    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("timeout_count", to_seen, to_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
